// File: rtl/qspi_read_buffer.sv
// qspi_read_buffer: first-word-fall-through word FIFO between the QSPI
// datapath sample register and the AHB slave read path. It also tracks
// popped beats against the active burst length and pulses burst_done_out
// when the last beat of a burst has been consumed.
module qspi_read_buffer #(
    parameter int DEPTH      = 16,
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic        h_clk,
    input  logic        h_rstn,
    input  logic [31:0] data_sample_reg_in,
    input  logic        push_in,
    input  logic        pop_in,
    input  logic        flush_in,
    input  logic        start_burst_in,
    input  logic [4:0]  burst_beats_in,
    output logic [31:0] rdata_out,
    output logic        rdata_valid_out,
    output logic        full_out,
    output logic        empty_out,
    output logic [4:0]  count_out,
    output logic        burst_active_out,
    output logic        burst_done_out,
    output logic        overflow_err_out
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } burst_state_t;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   wdata;
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [4:0]    count_reg;
    logic [4:0]    count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          ovf_reg;
    logic          pop_ok;
    logic          push_ok;
    logic [4:0]    beats_load;

    burst_state_t  state_reg;
    burst_state_t  state_next;
    logic [4:0]    beats_reg;
    logic [4:0]    beats_next;
    logic          done_reg;
    logic          done_next;

    // Byte lane routing: optionally reverse the four bytes so an MSB-first
    // flash word lands little-endian on the AHB side.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        if (SWAP_BYTES) begin : g_swap
            assign wdata[8*gi +: 8] = data_sample_reg_in[8*(3-gi) +: 8];
        end else begin : g_pass
            assign wdata[8*gi +: 8] = data_sample_reg_in[8*gi +: 8];
        end
    end

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // accepted when a valid pop frees the head slot in the same cycle.
    assign pop_ok     = pop_in && (count_reg != 5'd0);
    assign push_ok    = push_in && ((count_reg < DEPTH_CNT) || pop_ok);
    assign beats_load = (burst_beats_in == 5'd0) ? 5'd1 : burst_beats_in;

    // Occupancy update; flush overrides any concurrent push/pop.
    always_comb begin
        count_next = count_reg;
        if (flush_in) begin
            count_next = 5'd0;
        end else if (push_ok && !pop_ok) begin
            count_next = count_reg + 5'd1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 5'd1;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge h_clk) begin
        if (push_ok && !flush_in) begin
            mem[wptr_reg] <= wdata;
        end
    end

    // Pointers, occupancy, registered full/empty flags and sticky overflow.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= 5'd0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_CNT);
            empty_reg <= (count_next == 5'd0);
            if (flush_in) begin
                wptr_reg <= '0;
                rptr_reg <= '0;
                ovf_reg  <= 1'b0;
            end else begin
                if (push_ok) begin
                    wptr_reg <= wptr_reg + 1'b1;
                end
                if (pop_ok) begin
                    rptr_reg <= rptr_reg + 1'b1;
                end
                if (push_in && !push_ok) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    // Burst tracker next state: a reload always wins over the final pop.
    always_comb begin
        state_next = state_reg;
        beats_next = beats_reg;
        done_next  = 1'b0;
        if (flush_in) begin
            state_next = ST_IDLE;
            beats_next = 5'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_burst_in) begin
                        beats_next = beats_load;
                        state_next = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (start_burst_in) begin
                        beats_next = beats_load;
                    end else if (pop_ok) begin
                        if (beats_reg <= 5'd1) begin
                            beats_next = 5'd0;
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            beats_next = beats_reg - 5'd1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Burst tracker state register.
    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            state_reg <= ST_IDLE;
            beats_reg <= 5'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            beats_reg <= beats_next;
            done_reg  <= done_next;
        end
    end

    assign rdata_out        = empty_reg ? 32'd0 : mem[rptr_reg];
    assign rdata_valid_out  = !empty_reg;
    assign full_out         = full_reg;
    assign empty_out        = empty_reg;
    assign count_out        = count_reg;
    assign burst_active_out = (state_reg == ST_ACTIVE);
    assign burst_done_out   = done_reg;
    assign overflow_err_out = ovf_reg;

endmodule

// File: tb/tb_qspi_read_buffer.sv
// Directed testbench for qspi_read_buffer. Two instances share all inputs:
// one stores words as received, the other byte-reverses them.
`timescale 1ns/1ps
module tb_qspi_read_buffer;

    logic        h_clk = 1'b0;
    logic        h_rstn = 1'b0;
    logic [31:0] data_sample_reg_in = '0;
    logic        push_in = 1'b0;
    logic        pop_in = 1'b0;
    logic        flush_in = 1'b0;
    logic        start_burst_in = 1'b0;
    logic [4:0]  burst_beats_in = '0;

    logic [31:0] rdata_out;
    logic        rdata_valid_out, full_out, empty_out;
    logic [4:0]  count_out;
    logic        burst_active_out, burst_done_out, overflow_err_out;

    logic [31:0] sw_rdata;
    logic        sw_valid, sw_full, sw_empty;
    logic [4:0]  sw_count;
    logic        sw_active, sw_done, sw_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 h_clk = ~h_clk;

    qspi_read_buffer #(.DEPTH(16), .SWAP_BYTES(1'b0)) dut (
        .h_clk(h_clk), .h_rstn(h_rstn),
        .data_sample_reg_in(data_sample_reg_in),
        .push_in(push_in), .pop_in(pop_in), .flush_in(flush_in),
        .start_burst_in(start_burst_in), .burst_beats_in(burst_beats_in),
        .rdata_out(rdata_out), .rdata_valid_out(rdata_valid_out),
        .full_out(full_out), .empty_out(empty_out), .count_out(count_out),
        .burst_active_out(burst_active_out), .burst_done_out(burst_done_out),
        .overflow_err_out(overflow_err_out)
    );

    qspi_read_buffer #(.DEPTH(16), .SWAP_BYTES(1'b1)) dut_swap (
        .h_clk(h_clk), .h_rstn(h_rstn),
        .data_sample_reg_in(data_sample_reg_in),
        .push_in(push_in), .pop_in(pop_in), .flush_in(flush_in),
        .start_burst_in(start_burst_in), .burst_beats_in(burst_beats_in),
        .rdata_out(sw_rdata), .rdata_valid_out(sw_valid),
        .full_out(sw_full), .empty_out(sw_empty), .count_out(sw_count),
        .burst_active_out(sw_active), .burst_done_out(sw_done),
        .overflow_err_out(sw_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance one clock and settle just past the edge before sampling.
    task automatic tick();
        @(posedge h_clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        data_sample_reg_in = d;
        push_in = 1'b1;
        tick();
        push_in = 1'b0;
    endtask

    task automatic pop_word();
        pop_in = 1'b1;
        tick();
        pop_in = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_valid", 32'(rdata_valid_out), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_active", 32'(burst_active_out), 32'd0);
        check("rst_done", 32'(burst_done_out), 32'd0);
        check("rst_ovf", 32'(overflow_err_out), 32'd0);
        h_rstn = 1'b1;
        tick();

        // Single word, no swap / swap
        push_word(32'h11223344);
        check("push1_rdata", rdata_out, 32'h11223344);
        check("push1_valid", 32'(rdata_valid_out), 32'd1);
        check("push1_count", 32'(count_out), 32'd1);
        check("push1_swap_rdata", sw_rdata, 32'h44332211);
        pop_word();
        check("pop1_empty", 32'(empty_out), 32'd1);
        check("pop1_rdata", rdata_out, 32'd0);
        check("pop1_count", 32'(count_out), 32'd0);

        push_word(32'hAABBCCDD);
        check("swap_rdata", sw_rdata, 32'hDDCCBBAA);
        check("noswap_rdata", rdata_out, 32'hAABBCCDD);
        pop_word();

        // Overfill with 17 words
        for (int i = 0; i < 17; i++) begin
            push_word(32'(i));
        end
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_count", 32'(count_out), 32'd16);
        check("fill_ovf", 32'(overflow_err_out), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), rdata_out, 32'(i));
            pop_word();
        end
        check("drain_empty", 32'(empty_out), 32'd1);
        check("drain_count", 32'(count_out), 32'd0);
        check("drain_ovf_sticky", 32'(overflow_err_out), 32'd1);

        // Flush clears the sticky error
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("flush_ovf", 32'(overflow_err_out), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 16; i++) begin
            push_word(32'h200 + 32'(i));
        end
        check("full2_full", 32'(full_out), 32'd1);
        data_sample_reg_in = 32'h2FF;
        push_in = 1'b1;
        pop_in = 1'b1;
        tick();
        push_in = 1'b0;
        pop_in = 1'b0;
        check("pp_count", 32'(count_out), 32'd16);
        check("pp_full", 32'(full_out), 32'd1);
        check("pp_ovf", 32'(overflow_err_out), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("pp_drain_%0d", i), rdata_out, 32'h200 + 32'(i));
            pop_word();
        end
        check("pp_last", rdata_out, 32'h2FF);
        pop_word();
        check("pp_empty", 32'(empty_out), 32'd1);

        // Burst of 4
        burst_beats_in = 5'd4;
        start_burst_in = 1'b1;
        tick();
        start_burst_in = 1'b0;
        check("b4_active", 32'(burst_active_out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            push_word(32'h300 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            pop_word();
            check($sformatf("b4_nodone_%0d", i), 32'(burst_done_out), 32'd0);
        end
        check("b4_still_active", 32'(burst_active_out), 32'd1);
        pop_word();
        check("b4_done", 32'(burst_done_out), 32'd1);
        check("b4_active_fall", 32'(burst_active_out), 32'd0);
        tick();
        check("b4_done_once", 32'(burst_done_out), 32'd0);
        pop_word();
        check("b4_extra_count", 32'(count_out), 32'd0);
        check("b4_extra_empty", 32'(empty_out), 32'd1);
        check("b4_extra_done", 32'(burst_done_out), 32'd0);

        // Zero beats is treated as one
        burst_beats_in = 5'd0;
        start_burst_in = 1'b1;
        tick();
        start_burst_in = 1'b0;
        push_word(32'h400);
        pop_word();
        check("b0_done", 32'(burst_done_out), 32'd1);
        check("b0_active", 32'(burst_active_out), 32'd0);

        // Overflow, burst, then flush together with push
        for (int i = 0; i < 3; i++) begin
            push_word(32'h500 + 32'(i));
        end
        for (int i = 3; i < 17; i++) begin
            push_word(32'h500 + 32'(i));
        end
        check("f_ovf_set", 32'(overflow_err_out), 32'd1);
        burst_beats_in = 5'd8;
        start_burst_in = 1'b1;
        tick();
        start_burst_in = 1'b0;
        check("f_active", 32'(burst_active_out), 32'd1);
        data_sample_reg_in = 32'hDEAD0001;
        flush_in = 1'b1;
        push_in = 1'b1;
        tick();
        flush_in = 1'b0;
        push_in = 1'b0;
        check("f_count", 32'(count_out), 32'd0);
        check("f_empty", 32'(empty_out), 32'd1);
        check("f_active_clr", 32'(burst_active_out), 32'd0);
        check("f_ovf_clr", 32'(overflow_err_out), 32'd0);
        check("f_rdata", rdata_out, 32'd0);
        tick();
        check("f_discarded", 32'(count_out), 32'd0);

        // Reset in the middle of a burst
        burst_beats_in = 5'd4;
        start_burst_in = 1'b1;
        tick();
        start_burst_in = 1'b0;
        push_word(32'h600);
        push_word(32'h601);
        pop_word();
        #2;
        h_rstn = 1'b0;
        #1;
        check("mr_active", 32'(burst_active_out), 32'd0);
        check("mr_count", 32'(count_out), 32'd0);
        tick();
        h_rstn = 1'b1;
        tick();
        check("mr_done", 32'(burst_done_out), 32'd0);
        check("mr_empty", 32'(empty_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
